// File: rtl/uart_ns_rx_buf_ctrl.sv
// UART receive buffer controller: FWFT byte FIFO behind a UART receiver, with sticky
// overrun/frame-error flags, a bit-time character timeout and a registered interrupt.
module uart_ns_rx_buf_ctrl #(
    parameter int DEPTH      = 8,
    parameter int BAUD_DIV_W = 16,
    parameter int TO_BITS    = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BAUD_DIV_W-1:0]   baud_div_i,
    input  logic                    rx_en_i,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_valid_i,
    input  logic                    rx_frame_err_i,
    input  logic                    pop_i,
    input  logic                    fifo_clr_i,
    input  logic                    sts_clr_i,
    input  logic [$clog2(DEPTH):0]  thresh_i,
    output logic [7:0]              rd_data_o,
    output logic                    rd_valid_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overrun_o,
    output logic                    frame_err_o,
    output logic                    timeout_o,
    output logic                    irq_o
);
    // Timeout FSM
    //   state      | meaning
    //   TO_IDLE    | FIFO empty, no timeout pending
    //   TO_COUNT   | FIFO holds data, counting idle bit-times
    //   TO_EXPIRED | TO_BITS idle bit-times elapsed, timeout_o asserted

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TO_BITS + 1);

    typedef enum logic [1:0] {
        TO_IDLE,
        TO_COUNT,
        TO_EXPIRED
    } to_state_e;

    logic [7:0]            mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic [BAUD_DIV_W-1:0] presc_q, presc_d;
    logic [TW-1:0]         bit_cnt_q, bit_cnt_d;
    to_state_e             to_state_q, to_state_d;
    logic                  irq_q, irq_d;

    logic                  empty;
    logic                  full;
    logic                  rx_evt;
    logic                  push_en;
    logic                  pop_en;
    logic                  overrun_evt;
    logic [BAUD_DIV_W-1:0] div_eff;
    logic                  tick;

    // FIFO datapath; a flush overrides any same-cycle push or pop
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CW'(DEPTH));
        rx_evt      = rx_valid_i & rx_en_i;
        pop_en      = pop_i & ~empty & ~fifo_clr_i;
        push_en     = rx_evt & (~full | pop_i) & ~fifo_clr_i;
        overrun_evt = rx_evt & full & ~pop_i & ~fifo_clr_i;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_en && !pop_en) begin
                count_d = count_q + CW'(1);
            end else if (pop_en && !push_en) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Sticky flags: a new event in the clear cycle keeps the flag set
    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (sts_clr_i) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end
        if (rx_frame_err_i && rx_en_i) begin
            frame_err_d = 1'b1;
        end
    end

    // Bit-time prescaler, realigned to every FIFO access
    always_comb begin
        div_eff = (baud_div_i == '0) ? BAUD_DIV_W'(1) : baud_div_i;
        tick    = (presc_q >= (div_eff - BAUD_DIV_W'(1)));
        if (push_en || pop_en || fifo_clr_i || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + BAUD_DIV_W'(1);
        end
    end

    always_comb begin
        to_state_d = to_state_q;
        bit_cnt_d  = bit_cnt_q;
        if (fifo_clr_i || (count_d == '0)) begin
            to_state_d = TO_IDLE;
            bit_cnt_d  = '0;
        end else if (push_en || pop_en) begin
            to_state_d = TO_COUNT;
            bit_cnt_d  = '0;
        end else begin
            case (to_state_q)
                TO_IDLE: begin
                    to_state_d = TO_COUNT;
                    bit_cnt_d  = '0;
                end
                TO_COUNT: begin
                    if (tick) begin
                        if (bit_cnt_q >= TW'(TO_BITS - 1)) begin
                            to_state_d = TO_EXPIRED;
                        end else begin
                            bit_cnt_d = bit_cnt_q + TW'(1);
                        end
                    end
                end
                TO_EXPIRED: begin
                    to_state_d = TO_EXPIRED;
                end
                default: begin
                    to_state_d = TO_IDLE;
                    bit_cnt_d  = '0;
                end
            endcase
        end
    end

    // Interrupt built from next-state values so it lines up with the flags it reflects
    always_comb begin
        irq_d = ((thresh_i != '0) && (count_d >= thresh_i))
              | (to_state_d == TO_EXPIRED)
              | overrun_d
              | frame_err_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            presc_q     <= '0;
            bit_cnt_q   <= '0;
            to_state_q  <= TO_IDLE;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            presc_q     <= presc_d;
            bit_cnt_q   <= bit_cnt_d;
            to_state_q  <= to_state_d;
            irq_q       <= irq_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents
    always_ff @(posedge clk) begin
        if (rst_n && push_en) begin
            mem_q[wr_ptr_q] <= rx_data_i;
        end
    end

    assign rd_data_o   = mem_q[rd_ptr_q];
    assign rd_valid_o  = ~empty;
    assign count_o     = count_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;
    assign timeout_o   = (to_state_q == TO_EXPIRED);
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_uart_ns_rx_buf_ctrl.sv
// Bench for uart_ns_rx_buf_ctrl: directed stimulus, popped bytes checked by a
// scoreboard monitor, status/occupancy checked against hand-computed constants.
module tb_uart_ns_rx_buf_ctrl;
    logic        clk;
    logic        rst_n;
    logic [15:0] baud_div_i;
    logic        rx_en_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_frame_err_i;
    logic        pop_i;
    logic        fifo_clr_i;
    logic        sts_clr_i;
    logic [3:0]  thresh_i;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic [3:0]  count_o;
    logic        overrun_o;
    logic        frame_err_o;
    logic        timeout_o;
    logic        irq_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  sb[$];

    uart_ns_rx_buf_ctrl #(.DEPTH(8), .BAUD_DIV_W(16), .TO_BITS(40)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .baud_div_i     (baud_div_i),
        .rx_en_i        (rx_en_i),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_frame_err_i (rx_frame_err_i),
        .pop_i          (pop_i),
        .fifo_clr_i     (fifo_clr_i),
        .sts_clr_i      (sts_clr_i),
        .thresh_i       (thresh_i),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .count_o        (count_o),
        .overrun_o      (overrun_o),
        .frame_err_o    (frame_err_o),
        .timeout_o      (timeout_o),
        .irq_o          (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // Scoreboard monitor: every accepted pop must present the oldest expected byte
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (rst_n && pop_i && rd_valid_o) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL pop_data: got %02h, want nothing (scoreboard empty)", rd_data_o);
            end else begin
                exp_b = sb.pop_front();
                if (rd_data_o !== exp_b) begin
                    n_err++;
                    $display("FAIL pop_data: got %02h, want %02h", rd_data_o, exp_b);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic do_push(input logic [7:0] b, input bit accepted);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        if (accepted) sb.push_back(b);
        cyc();
        rx_valid_i = 1'b0;
    endtask

    task automatic do_pop();
        pop_i = 1'b1;
        cyc();
        pop_i = 1'b0;
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_count"},     int'(count_o),     0);
        chk({tag, "_rd_valid"},  int'(rd_valid_o),  0);
        chk({tag, "_overrun"},   int'(overrun_o),   0);
        chk({tag, "_frame_err"}, int'(frame_err_o), 0);
        chk({tag, "_timeout"},   int'(timeout_o),   0);
        chk({tag, "_irq"},       int'(irq_o),       0);
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        baud_div_i     = 16'd4;
        rx_en_i        = 1'b1;
        rx_data_i      = 8'h00;
        rx_valid_i     = 1'b0;
        rx_frame_err_i = 1'b0;
        pop_i          = 1'b0;
        fifo_clr_i     = 1'b0;
        sts_clr_i      = 1'b0;
        thresh_i       = 4'd0;
        cyc();
        cyc();
        chk_all_reset("reset");
        rst_n = 1'b1;
        cyc();

        // basic FWFT ordering
        do_push(8'h11, 1'b1);
        do_push(8'h22, 1'b1);
        do_push(8'h33, 1'b1);
        chk("fwft_count3", int'(count_o), 3);
        chk("fwft_head", int'(rd_data_o), 'h11);
        do_pop();
        chk("fwft_head_after_pop", int'(rd_data_o), 'h22);
        do_pop();
        do_pop();
        chk("fwft_empty_valid", int'(rd_valid_o), 0);
        chk("fwft_empty_count", int'(count_o), 0);
        do_pop();
        chk("pop_on_empty_count", int'(count_o), 0);

        // fill to DEPTH, ninth byte dropped
        for (int i = 1; i <= 8; i++) do_push(8'(i), 1'b1);
        chk("full_no_overrun", int'(overrun_o), 0);
        do_push(8'h09, 1'b0);
        chk("ovr_count", int'(count_o), 8);
        chk("ovr_flag", int'(overrun_o), 1);
        chk("ovr_irq", int'(irq_o), 1);
        chk("ovr_head_unchanged", int'(rd_data_o), 1);
        sts_clr_i = 1'b1;
        cyc();
        sts_clr_i = 1'b0;
        chk("ovr_cleared", int'(overrun_o), 0);
        chk("ovr_irq_cleared", int'(irq_o), 0);

        // full FIFO: push and pop in the same cycle
        rx_data_i  = 8'hAA;
        rx_valid_i = 1'b1;
        pop_i      = 1'b1;
        sb.push_back(8'hAA);
        cyc();
        rx_valid_i = 1'b0;
        pop_i      = 1'b0;
        chk("full_pushpop_count", int'(count_o), 8);
        chk("full_pushpop_overrun", int'(overrun_o), 0);
        chk("full_pushpop_head", int'(rd_data_o), 2);
        for (int i = 0; i < 8; i++) do_pop();
        chk("drain_valid", int'(rd_valid_o), 0);

        // character timeout: 40 bit-times of 4 clocks
        do_push(8'h5A, 1'b1);
        n = 0;
        while (!timeout_o && n < 200) begin
            cyc();
            n++;
        end
        chk("timeout_latency", n, 160);
        chk("timeout_irq", int'(irq_o), 1);
        do_pop();
        chk("timeout_cleared_by_pop", int'(timeout_o), 0);
        chk("timeout_irq_cleared", int'(irq_o), 0);

        // watermark interrupt and flush priority
        thresh_i = 4'd4;
        do_push(8'h01, 1'b1);
        do_push(8'h02, 1'b1);
        do_push(8'h03, 1'b1);
        chk("wm_below_irq", int'(irq_o), 0);
        do_push(8'h04, 1'b1);
        chk("wm_at_irq", int'(irq_o), 1);
        chk("wm_count", int'(count_o), 4);
        fifo_clr_i = 1'b1;
        rx_data_i  = 8'h55;
        rx_valid_i = 1'b1;
        sb.delete();
        cyc();
        fifo_clr_i = 1'b0;
        rx_valid_i = 1'b0;
        chk("clr_count", int'(count_o), 0);
        chk("clr_irq", int'(irq_o), 0);
        chk("clr_valid", int'(rd_valid_o), 0);

        // frame error, receive disable, reset mid-timeout
        do_push(8'h77, 1'b1);
        rx_frame_err_i = 1'b1;
        cyc();
        rx_frame_err_i = 1'b0;
        chk("ferr_flag", int'(frame_err_o), 1);
        chk("ferr_count", int'(count_o), 1);
        chk("ferr_irq", int'(irq_o), 1);
        rx_en_i = 1'b0;
        do_push(8'h99, 1'b0);
        chk("rx_dis_count", int'(count_o), 1);
        rx_en_i   = 1'b1;
        sts_clr_i = 1'b1;
        cyc();
        sts_clr_i = 1'b0;
        chk("ferr_cleared", int'(frame_err_o), 0);
        rx_frame_err_i = 1'b1;
        cyc();
        rx_frame_err_i = 1'b0;
        for (int i = 0; i < 50; i++) cyc();
        chk("mid_timeout_not_expired", int'(timeout_o), 0);
        rst_n = 1'b0;
        cyc();
        sb.delete();
        chk_all_reset("midrst");
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) cyc();
        chk("post_rst_no_timeout", int'(timeout_o), 0);
        do_push(8'h3C, 1'b1);
        chk("post_rst_count", int'(count_o), 1);
        chk("post_rst_head", int'(rd_data_o), 'h3C);
        do_pop();
        chk("post_rst_empty", int'(rd_valid_o), 0);
        cyc();
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_ns_rx_buf_ctrl.md
UART_NS_RX_BUF_CTRL -- requirements
Module: uart_ns_rx_buf_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter BAUD_DIV_W, default 16, meaning baud_div_i width.
REQ-003 SHALL have parameter TO_BITS, default 40, meaning idle bit-times before char timeout.
REQ-004 SHALL provide clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL provide rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL provide baud_div_i  input  BAUD_DIV_W  clocks per bit, same value the receiver uses.
REQ-007 SHALL provide rx_en_i  input  1  receive enable; low = ignore receiver events.
REQ-008 SHALL provide rx_data_i  input  8  received byte from receiver.
REQ-009 SHALL provide rx_valid_i  input  1  one-cycle pulse, rx_data_i valid.
REQ-010 SHALL provide rx_frame_err_i  input  1  one-cycle pulse, stop bit was low.
REQ-011 SHALL provide pop_i  input  1  consume head entry (one entry per cycle high).
REQ-012 SHALL provide fifo_clr_i  input  1  pulse, flush FIFO.
REQ-013 SHALL provide sts_clr_i  input  1  pulse, clear sticky overrun/frame-error flags.
REQ-014 SHALL provide thresh_i  input  $clog2(DEPTH)+1  watermark; 0 disables watermark irq.
REQ-015 SHALL provide rd_data_o  output  8  head entry (first-word-fall-through).
REQ-016 SHALL provide rd_valid_o  output  1  FIFO not empty.
REQ-017 SHALL provide count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-018 SHALL provide overrun_o, frame_err_o, timeout_o  output  1 each  status flags.
REQ-019 SHALL provide irq_o  output  1  level interrupt.

Function
REQ-020 SHALL push rx_data_i when rx_valid_i=1, rx_en_i=1, and FIFO not full (or full with pop_i=1 same cycle); count_o/rd_valid_o reflect it the next cycle.
REQ-021 SHALL, on rx_valid_i=1 with rx_en_i=1, FIFO full and pop_i=0, drop the byte, leave contents unchanged, set overrun_o next cycle.
REQ-022 SHALL ignore pop_i when empty; count never underflows nor exceeds DEPTH; pointers wrap modulo DEPTH.
REQ-023 SHALL, on simultaneous push and pop, keep count unchanged and present the next entry on rd_data_o next cycle.
REQ-024 SHALL set frame_err_o on rx_frame_err_i=1 with rx_en_i=1; no byte pushed.
REQ-025 SHALL give fifo_clr_i priority over push/pop: count=0 next cycle, same-cycle push discarded, timeout FSM to TO_IDLE.
REQ-026 SHALL hold overrun_o/frame_err_o until sts_clr_i; a set event in the same cycle as sts_clr_i wins.
REQ-027 SHALL generate a bit tick every max(baud_div_i,1) clocks from a free-running prescaler restarted on any push, pop, or clear.
REQ-028 SHALL run timeout FSM TO_IDLE -> TO_COUNT when FIFO non-empty; TO_COUNT counts ticks; reaching TO_BITS -> TO_EXPIRED (timeout_o=1).
REQ-029 SHALL return to TO_COUNT with bit count 0 on push or pop while non-empty, and to TO_IDLE when FIFO becomes empty, from any state.
REQ-030 SHALL drive irq_o = (thresh_i!=0 and count_o>=thresh_i) or timeout_o or overrun_o or frame_err_o, registered.
REQ-031 SHALL ignore receiver events with rx_en_i=0 while still serving pops and timeout.

Reset
REQ-032 SHALL, with rst_n=0 at a clk edge, set count_o=0, rd_valid_o=0, overrun_o=0, frame_err_o=0, timeout_o=0, irq_o=0, pointers=0, FSM=TO_IDLE, prescaler and bit count=0.
REQ-033 SHALL abort any in-progress timeout count on reset mid-operation; FIFO contents are discarded.
REQ-034 SHALL leave rd_data_o content don't-care while rd_valid_o=0.

Verification
REQ-035 SHALL cover: push 0x11,0x22,0x33 -> count_o=3, rd_data_o=0x11; three pops -> 0x22, 0x33, then rd_valid_o=0.
REQ-036 SHALL cover: 9 pushes with DEPTH=8, no pop -> 9th dropped, overrun_o=1, irq_o=1; sts_clr_i -> overrun_o=0.
REQ-037 SHALL cover: full FIFO, push 0xAA with pop same cycle -> count_o stays 8, 0xAA last read, overrun_o=0.
REQ-038 SHALL cover: baud_div_i=4, one push, no activity -> timeout_o=1 exactly 160 clocks after push; pop -> timeout_o=0.
REQ-039 SHALL cover: thresh_i=4, pushes 1..4 -> irq_o rises after 4th; fifo_clr_i with push same cycle -> count_o=0, irq_o=0.
REQ-040 SHALL cover: rx_frame_err_i pulse -> frame_err_o=1, count unchanged; rst_n=0 mid-timeout -> all outputs reset values.
